move_list_walker: RTL and testbench
===================================

MOVE_LIST_WALKER -- requirements
Module: move_list_walker

Interface
REQ-001 Parameter MAX_POSITIONS_LOG2, default 8, width of move index and move count.
REQ-002 Parameter EVAL_WIDTH, default 24, width of signed evaluation.
REQ-003 Parameter UCI_WIDTH, default 16, width of UCI move code {promotion[3:0], to[5:0], from[5:0]}.
REQ-004 Parameter READ_LATENCY, default 2, cycles from am_move_index change to valid move RAM data (legal range 1..7).
REQ-005 One clock and one reset: clk in 1, rising-edge clock; reset in 1, synchronous, active-high.
REQ-006 start_in  in  1  request to evaluate the currently presented board (sampled in IDLE only).
REQ-007 abort_in  in  1  abandon current walk.
REQ-008 busy_out  out  1  high in every state except IDLE.
REQ-009 board_valid_out  out  1  one-cycle pulse to all_moves board_valid_in.
REQ-010 am_moves_ready  in  1  from all_moves: move list complete.
REQ-011 am_idle  in  1  from all_moves: generator idle.
REQ-012 am_move_count  in  MAX_POSITIONS_LOG2  number of legal moves.
REQ-013 am_move_index  out  MAX_POSITIONS_LOG2  move RAM read address.
REQ-014 am_clear_moves  out  1  one-cycle pulse releasing the move list.
REQ-015 uci_in / eval_in / capture_in  in  UCI_WIDTH / EVAL_WIDTH / 1  move RAM read data.
REQ-016 mv_valid_out, mv_ready_in  out/in  1  downstream move stream handshake.
REQ-017 mv_uci_out / mv_eval_out / mv_capture_out / mv_index_out / mv_last_out  out  per REQ-015 / MAX_POSITIONS_LOG2 / 1  move payload.
REQ-018 done_out  out  1  one-cycle pulse at walk end; no_moves_out  out  1  registered, high if the finished walk had count 0.

Function
REQ-019 States: IDLE, LOAD, WAIT_READY, ADDR, PRESENT, CLEAR, WAIT_IDLE.
REQ-020 IDLE: start_in=1 -> LOAD; am_move_index held 0.
REQ-021 LOAD: board_valid_out=1 for exactly this cycle -> WAIT_READY.
REQ-022 WAIT_READY: on am_moves_ready, latch am_move_count; count=0 -> CLEAR with no_moves_out=1; else index=0, -> ADDR.
REQ-023 ADDR: latency counter counts READ_LATENCY cycles after the index is set, then registers uci/eval/capture into payload -> PRESENT.
REQ-024 PRESENT: mv_valid_out=1, payload stable until mv_valid_out&mv_ready_in; mv_last_out=1 iff index = latched count-1.
REQ-025 On handshake: not last -> index+1, ADDR; last -> CLEAR; index never wraps.
REQ-026 CLEAR: am_clear_moves=1 for exactly one cycle -> WAIT_IDLE.
REQ-027 WAIT_IDLE: wait minimum 1 cycle and until am_idle=1, then done_out=1 for one cycle -> IDLE.
REQ-028 abort_in in LOAD, WAIT_READY, ADDR or PRESENT -> CLEAR next cycle, mv_valid_out dropped immediately, no partial handshake completes; abort_in in IDLE, CLEAR, WAIT_IDLE ignored.
REQ-029 abort_in and handshake in same cycle: abort wins, index not incremented.
REQ-030 start_in outside IDLE ignored, not queued.
REQ-031 mv_valid_out shall never assert outside PRESENT; board_valid_out and am_clear_moves never assert simultaneously.

Reset
REQ-032 reset shall force IDLE and all outputs 0 (board_valid_out, am_clear_moves, am_move_index, mv_*_out, done_out, no_moves_out, busy_out) on the next edge.
REQ-033 reset mid-walk shall not emit am_clear_moves; all_moves is reset by the same signal.

Structure
REQ-034 State encodings and UCI field offsets (promotion/to/from) shall live in the shared vchess header alongside MAX_POSITIONS.
REQ-035 No sub-module; latency counter and state machine are in one module.

Verification
REQ-036 Behavioural all_moves model, count=3, READ_LATENCY=2, mv_ready_in=1 -> one board_valid pulse, three moves indices 0,1,2, last on index 2, one clear pulse, done_out.
REQ-037 count=0 (mate position) -> no mv_valid_out, am_clear_moves once, done_out with no_moves_out=1.
REQ-038 mv_ready_in low 5 cycles on index 1 -> payload and am_move_index stable for all 5 cycles.
REQ-039 abort_in during PRESENT index 1 of 20 -> mv_valid_out low next cycle, one clear pulse, done_out, next start_in walks from index 0.
REQ-040 reset asserted in ADDR -> all outputs 0 next cycle, no am_clear_moves pulse; am_idle held low 4 cycles after clear -> done_out delayed exactly 4 cycles.

Source files
------------

// File: rtl/move_list_walker_pkg.sv
// Shared vchess definitions: walker state encoding, UCI move-code field layout and board limits.
// Imported by the move list walker and by anything that builds or decodes UCI move codes.
package move_list_walker_pkg;

    localparam int MAX_POSITIONS = 256;

    localparam int UCI_FROM_LSB  = 0;
    localparam int UCI_TO_LSB    = 6;
    localparam int UCI_PROMO_LSB = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_READY,
        ST_ADDR,
        ST_PRESENT,
        ST_CLEAR,
        ST_WAIT_IDLE
    } walk_state_e;

    function automatic logic [15:0] make_uci(input logic [3:0] promo,
                                             input logic [5:0] to_sq,
                                             input logic [5:0] from_sq);
        return (16'(promo) << UCI_PROMO_LSB) | (16'(to_sq) << UCI_TO_LSB) |
               (16'(from_sq) << UCI_FROM_LSB);
    endfunction

endpackage

// File: rtl/move_list_walker.sv
// Walks the all_moves move list: one move per READ_LATENCY+1 cycle fetch, then valid/ready hand-off.
// Payload is held stable under mv_ready_in backpressure; abort_in drops mv_valid_out in the same cycle.
module move_list_walker
    import move_list_walker_pkg::*;
#(
    parameter int MAX_POSITIONS_LOG2 = 8,
    parameter int EVAL_WIDTH         = 24,
    parameter int UCI_WIDTH          = 16,
    parameter int READ_LATENCY       = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start_in,
    input  logic                          abort_in,
    output logic                          busy_out,
    output logic                          board_valid_out,
    input  logic                          am_moves_ready,
    input  logic                          am_idle,
    input  logic [MAX_POSITIONS_LOG2-1:0] am_move_count,
    output logic [MAX_POSITIONS_LOG2-1:0] am_move_index,
    output logic                          am_clear_moves,
    input  logic [UCI_WIDTH-1:0]          uci_in,
    input  logic [EVAL_WIDTH-1:0]         eval_in,
    input  logic                          capture_in,
    output logic                          mv_valid_out,
    input  logic                          mv_ready_in,
    output logic [UCI_WIDTH-1:0]          mv_uci_out,
    output logic [EVAL_WIDTH-1:0]         mv_eval_out,
    output logic                          mv_capture_out,
    output logic [MAX_POSITIONS_LOG2-1:0] mv_index_out,
    output logic                          mv_last_out,
    output logic                          done_out,
    output logic                          no_moves_out
);

    localparam logic [2:0]                    LAT_LAST = 3'(READ_LATENCY);
    localparam logic [MAX_POSITIONS_LOG2-1:0] ONE      = MAX_POSITIONS_LOG2'(1);

    walk_state_e                   state_q, state_d;
    logic [MAX_POSITIONS_LOG2-1:0] index_q, index_d;
    logic [MAX_POSITIONS_LOG2-1:0] count_q, count_d;
    logic [2:0]                    lat_q, lat_d;
    logic [UCI_WIDTH-1:0]          uci_q, uci_d;
    logic [EVAL_WIDTH-1:0]         eval_q, eval_d;
    logic                          cap_q, cap_d;
    logic                          no_moves_q, no_moves_d;
    logic                          is_last;

    assign is_last = (index_q == count_q - ONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            index_q    <= '0;
            count_q    <= '0;
            lat_q      <= '0;
            uci_q      <= '0;
            eval_q     <= '0;
            cap_q      <= 1'b0;
            no_moves_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            count_q    <= count_d;
            lat_q      <= lat_d;
            uci_q      <= uci_d;
            eval_q     <= eval_d;
            cap_q      <= cap_d;
            no_moves_q <= no_moves_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        count_d    = count_q;
        lat_d      = lat_q;
        uci_d      = uci_q;
        eval_d     = eval_q;
        cap_d      = cap_q;
        no_moves_d = no_moves_q;
        unique case (state_q)
            ST_IDLE: begin
                index_d = '0;
                if (start_in) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                no_moves_d = 1'b0;
                state_d    = abort_in ? ST_CLEAR : ST_WAIT_READY;
            end
            ST_WAIT_READY: begin
                if (abort_in) begin
                    state_d = ST_CLEAR;
                end else if (am_moves_ready) begin
                    count_d = am_move_count;
                    index_d = '0;
                    lat_d   = '0;
                    if (am_move_count == '0) begin
                        no_moves_d = 1'b1;
                        state_d    = ST_CLEAR;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                // lat_q == READ_LATENCY is the first cycle the RAM reflects index_q
                if (abort_in) begin
                    state_d = ST_CLEAR;
                end else if (lat_q == LAT_LAST) begin
                    uci_d   = uci_in;
                    eval_d  = eval_in;
                    cap_d   = capture_in;
                    state_d = ST_PRESENT;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            ST_PRESENT: begin
                if (abort_in) begin
                    state_d = ST_CLEAR;
                end else if (mv_ready_in) begin
                    if (is_last) begin
                        state_d = ST_CLEAR;
                    end else begin
                        index_d = index_q + ONE;
                        lat_d   = '0;
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_CLEAR: state_d = ST_WAIT_IDLE;
            ST_WAIT_IDLE: begin
                if (am_idle) begin
                    index_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_out        = (state_q != ST_IDLE);
    assign board_valid_out = (state_q == ST_LOAD);
    assign am_clear_moves  = (state_q == ST_CLEAR);
    assign am_move_index   = index_q;
    assign mv_valid_out    = (state_q == ST_PRESENT) && !abort_in;
    assign mv_uci_out      = uci_q;
    assign mv_eval_out     = eval_q;
    assign mv_capture_out  = cap_q;
    assign mv_index_out    = index_q;
    assign mv_last_out     = (state_q == ST_PRESENT) && is_last;
    assign done_out        = (state_q == ST_WAIT_IDLE) && am_idle;
    assign no_moves_out    = no_moves_q;

endmodule

// File: tb/tb_move_list_walker.sv
// Bench for move_list_walker: behavioural all_moves model with a pipelined move RAM, scenario table, scoreboard.
module tb_move_list_walker;
    import move_list_walker_pkg::*;

    localparam int N  = 8;
    localparam int E  = 24;
    localparam int U  = 16;
    localparam int RL = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic         start_in = 1'b0, abort_in = 1'b0, mv_ready_in = 1'b0;
    logic         am_moves_ready, am_idle, capture_in;
    logic [N-1:0] am_move_count, am_move_index, mv_index_out;
    logic [U-1:0] uci_in, mv_uci_out;
    logic [E-1:0] eval_in, mv_eval_out;
    logic         busy_out, board_valid_out, am_clear_moves, mv_valid_out;
    logic         mv_capture_out, mv_last_out, done_out, no_moves_out;

    move_list_walker #(.MAX_POSITIONS_LOG2(N), .EVAL_WIDTH(E), .UCI_WIDTH(U), .READ_LATENCY(RL)) dut (
        .clk(clk), .reset(reset), .start_in(start_in), .abort_in(abort_in), .busy_out(busy_out),
        .board_valid_out(board_valid_out), .am_moves_ready(am_moves_ready), .am_idle(am_idle),
        .am_move_count(am_move_count), .am_move_index(am_move_index), .am_clear_moves(am_clear_moves),
        .uci_in(uci_in), .eval_in(eval_in), .capture_in(capture_in), .mv_valid_out(mv_valid_out),
        .mv_ready_in(mv_ready_in), .mv_uci_out(mv_uci_out), .mv_eval_out(mv_eval_out),
        .mv_capture_out(mv_capture_out), .mv_index_out(mv_index_out), .mv_last_out(mv_last_out),
        .done_out(done_out), .no_moves_out(no_moves_out)
    );

    // all_moves model: list ready 4 cycles after board_valid, idle returns cfg_idle cycles after clear
    logic [U-1:0] mem_uci  [MAX_POSITIONS];
    logic [E-1:0] mem_eval [MAX_POSITIONS];
    logic         mem_cap  [MAX_POSITIONS];
    logic [U-1:0] rd_uci   [RL];
    logic [E-1:0] rd_eval  [RL];
    logic         rd_cap   [RL];
    int           cfg_count = 0, cfg_idle = 0, rcnt, icnt;
    logic         m_ready, m_idle;

    assign am_moves_ready = m_ready;
    assign am_idle        = m_idle;
    assign am_move_count  = m_ready ? N'(cfg_count) : 8'd77;
    assign uci_in         = rd_uci[RL-1];
    assign eval_in        = rd_eval[RL-1];
    assign capture_in     = rd_cap[RL-1];

    always @(posedge clk) begin
        if (reset) begin
            rcnt <= 0; icnt <= 0; m_ready <= 1'b0; m_idle <= 1'b1;
        end else begin
            if (board_valid_out) begin
                rcnt <= 3; m_ready <= 1'b0; m_idle <= 1'b0;
            end else if (rcnt != 0) begin
                rcnt <= rcnt - 1;
                if (rcnt == 1) m_ready <= 1'b1;
            end
            if (am_clear_moves) begin
                m_ready <= 1'b0; icnt <= cfg_idle; m_idle <= (cfg_idle == 0);
            end else if (icnt != 0) begin
                icnt <= icnt - 1;
                if (icnt == 1) m_idle <= 1'b1;
            end
        end
        rd_uci[0]  <= mem_uci[am_move_index];
        rd_eval[0] <= mem_eval[am_move_index];
        rd_cap[0]  <= mem_cap[am_move_index];
        for (int k = 1; k < RL; k++) begin
            rd_uci[k]  <= rd_uci[k-1];
            rd_eval[k] <= rd_eval[k-1];
            rd_cap[k]  <= rd_cap[k-1];
        end
    end

    typedef struct packed {
        logic [U-1:0] uci;
        logic [E-1:0] eval;
        logic         cap;
        logic [N-1:0] idx;
        logic         last;
    } exp_t;

    typedef struct {
        string name;
        int    count;
        int    stall_idx;
        int    stall_cyc;
        int    abort_idx;
        int    idle_delay;
        int    exp_moves;
        int    exp_no_moves;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[6];
    int          checks = 0, errors = 0, cyc = 0;
    int          bv_cnt, clr_cnt, done_cnt, hs_cnt, overlap_cnt, stall_err, clear_cyc, done_cyc;
    logic        prev_stall = 1'b0;
    logic [57:0] snap = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs_now();
        return {board_valid_out, am_clear_moves, am_move_index, mv_valid_out, mv_uci_out, mv_eval_out,
                mv_capture_out, mv_index_out, mv_last_out, done_out, no_moves_out, busy_out};
    endfunction

    task automatic clear_counts();
        bv_cnt = 0; clr_cnt = 0; done_cnt = 0; hs_cnt = 0; overlap_cnt = 0; stall_err = 0;
        clear_cyc = 0; done_cyc = 0; prev_stall = 1'b0;
    endtask

    // Samples outputs mid-cycle, then returns 1 time unit after the next rising edge.
    task automatic tick();
        logic [57:0] now_snap;
        exp_t        got, e;
        @(negedge clk);
        cyc++;
        if (board_valid_out) bv_cnt++;
        if (am_clear_moves) begin clr_cnt++; clear_cyc = cyc; end
        if (done_out) begin done_cnt++; done_cyc = cyc; end
        if (board_valid_out && am_clear_moves) overlap_cnt++;
        if (mv_valid_out) begin
            now_snap = {am_move_index, mv_uci_out, mv_eval_out, mv_capture_out, mv_index_out, mv_last_out};
            if (prev_stall && now_snap !== snap) stall_err++;
            snap       = now_snap;
            prev_stall = !mv_ready_in;
            if (mv_ready_in) begin
                hs_cnt++;
                got = '{uci: mv_uci_out, eval: mv_eval_out, cap: mv_capture_out,
                        idx: mv_index_out, last: mv_last_out};
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_move: actual index=%0d required=no move", mv_index_out);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("move_idx%0d", e.idx), 64'(got), 64'(e));
                end
            end
        end else begin
            prev_stall = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < MAX_POSITIONS; i++) begin
            mem_uci[i]  = make_uci(4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)),
                                   6'($urandom_range(1, 63)));
            mem_eval[i] = E'($urandom);
            mem_cap[i]  = 1'($urandom);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int           stall_left;
        logic         aborted, v_now;
        logic [N-1:0] i_now;
        exp_t         e;
        fill_mem();
        cfg_count = v.count;
        cfg_idle  = v.idle_delay;
        for (int i = 0; i < v.exp_moves; i++) begin
            e = '{uci: mem_uci[i], eval: mem_eval[i], cap: mem_cap[i], idx: N'(i), last: (i == v.count - 1)};
            sb.push_back(e);
        end
        clear_counts();
        stall_left = v.stall_cyc;
        aborted    = 1'b0;
        start_in   = 1'b1;
        tick();
        for (int c = 0; c < 2000 && done_cnt == 0; c++) begin
            v_now       = mv_valid_out;
            i_now       = am_move_index;
            start_in    = 1'b0;
            abort_in    = 1'b0;
            mv_ready_in = 1'b1;
            if (!aborted && v_now) begin
                start_in = 1'b1;
                if (int'(i_now) == v.abort_idx) begin
                    abort_in = 1'b1;
                    aborted  = 1'b1;
                end else if (int'(i_now) == v.stall_idx && stall_left > 0) begin
                    mv_ready_in = 1'b0;
                    stall_left--;
                end
            end
            tick();
            if (abort_in) chk({v.name, "/abort_clear_next"}, 64'(am_clear_moves), 64'd1);
        end
        start_in = 1'b0; abort_in = 1'b0;
        if (done_cnt == 0) begin
            checks++; errors++;
            $display("FAIL %s/timeout: actual=no done_out required=done_out within 2000 cycles", v.name);
        end
        tick();
        chk({v.name, "/moves"}, 64'(hs_cnt), 64'(v.exp_moves));
        chk({v.name, "/sb_left"}, 64'(sb.size()), 64'd0);
        chk({v.name, "/board_valid"}, 64'(bv_cnt), 64'd1);
        chk({v.name, "/clears"}, 64'(clr_cnt), 64'd1);
        chk({v.name, "/dones"}, 64'(done_cnt), 64'd1);
        chk({v.name, "/overlap"}, 64'(overlap_cnt), 64'd0);
        chk({v.name, "/stall_stable"}, 64'(stall_err), 64'd0);
        chk({v.name, "/done_delay"}, 64'(done_cyc - clear_cyc), 64'(1 + v.idle_delay));
        chk({v.name, "/no_moves"}, 64'(no_moves_out), 64'(v.exp_no_moves));
        chk({v.name, "/busy_end"}, 64'(busy_out), 64'd0);
        sb.delete();
    endtask

    initial begin
        vecs[0] = '{"basic3",    3, -1, 0, -1, 0, 3, 0};
        vecs[1] = '{"mate0",     0, -1, 0, -1, 0, 0, 1};
        vecs[2] = '{"stall",     4,  1, 5, -1, 0, 4, 0};
        vecs[3] = '{"abort",    20, -1, 0,  1, 0, 1, 0};
        vecs[4] = '{"idle_wait", 3, -1, 0, -1, 4, 3, 0};
        vecs[5] = '{"single",    1, -1, 0, -1, 0, 1, 0};

        clear_counts();
        fill_mem();
        reset = 1'b1;
        repeat (3) tick();
        chk("reset_outputs", outs_now(), 64'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset while fetching index 1: walker idles with every output low and never clears.
        fill_mem();
        cfg_count = 3;
        cfg_idle  = 0;
        clear_counts();
        sb.push_back('{uci: mem_uci[0], eval: mem_eval[0], cap: mem_cap[0], idx: N'(0), last: 1'b0});
        mv_ready_in = 1'b1;
        start_in    = 1'b1;
        tick();
        start_in = 1'b0;
        for (int c = 0; c < 200 && hs_cnt == 0; c++) tick();
        chk("rst_mid/pre_index", 64'(am_move_index), 64'd1);
        chk("rst_mid/pre_payload_nonzero", 64'(mv_uci_out != '0), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid/outputs", outs_now(), 64'd0);
        repeat (6) tick();
        chk("rst_mid/no_clear", 64'(clr_cnt), 64'd0);
        chk("rst_mid/no_done", 64'(done_cnt), 64'd0);
        chk("rst_mid/idle", 64'(busy_out), 64'd0);
        sb.delete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
